// File: rtl/puzzle_pkg.sv
// Shared constants for the 8-puzzle processor: move codes and button indices.
package puzzle_pkg;

  typedef logic [2:0] mv_code_t;

  localparam mv_code_t MV_NONE   = 3'd0;
  localparam mv_code_t MV_UP     = 3'd1;
  localparam mv_code_t MV_DOWN   = 3'd2;
  localparam mv_code_t MV_LEFT   = 3'd3;
  localparam mv_code_t MV_RIGHT  = 3'd4;
  localparam mv_code_t MV_CENTRE = 3'd5;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTRE = 4;
  localparam int NUM_BTNS   = 5;

  // Button index to move code; the codes are the index plus one.
  function automatic mv_code_t btn_to_code(input int idx);
    case (idx)
      BTN_UP:     btn_to_code = MV_UP;
      BTN_DOWN:   btn_to_code = MV_DOWN;
      BTN_LEFT:   btn_to_code = MV_LEFT;
      BTN_RIGHT:  btn_to_code = MV_RIGHT;
      BTN_CENTRE: btn_to_code = MV_CENTRE;
      default:    btn_to_code = MV_NONE;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, hold counter, debounced level and a
// registered one-cycle pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Accept the synchronised value only after it has differed from the
  // current level for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
        cnt_d   = '0;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Synchroniser, counter, level and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/btn_move_queue.sv
// Button front end: five debouncers, a lowest-index-wins priority encoder
// and a small show-ahead FIFO of move codes with a sticky overflow flag.
module btn_move_queue
  import puzzle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DEPTH           = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [4:0]               btn,
  input  logic                     mv_pop,
  input  logic                     ovf_clr,
  output logic                     mv_valid,
  output logic [2:0]               mv_code,
  output logic [$clog2(DEPTH):0]   mv_count,
  output logic [4:0]               btn_level,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [NUM_BTNS-1:0] rise;
  mv_code_t            ev_code;
  logic                ev_any, ev_multi;

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count;
  logic          full, empty, pop_ok, push_ok, drop_full;
  logic          ovf_q, ovf_d;
  mv_code_t      mem [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn[gi]),
        .level(btn_level[gi]),
        .rise (rise[gi])
      );
    end
  endgenerate

  // Priority encode the press pulses; scanning downwards lets the lowest
  // index overwrite higher ones. More than one bit set means drops.
  always_comb begin
    ev_code  = MV_NONE;
    ev_any   = |rise;
    ev_multi = (rise & (rise - 5'd1)) != '0;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (rise[i]) ev_code = btn_to_code(i);
    end
  end

  // Occupancy comes from the extra-bit pointer difference, so full and
  // empty are distinguishable even when the index bits coincide.
  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == (AW + 1)'(DEPTH));
  assign empty     = (count == '0);
  assign pop_ok    = mv_pop & ~empty;
  assign push_ok   = ev_any & (~full | pop_ok);
  assign drop_full = ev_any & full & ~pop_ok;

  // Pointer advance and sticky overflow; a new drop beats a clear.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (ev_multi | drop_full) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage; when full with a pop the tail slot is the head slot, whose old
  // value has already been consumed combinationally this cycle.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= ev_code;
  end

  assign mv_valid = ~empty;
  assign mv_code  = empty ? MV_NONE : mem[rd_ptr_q[AW-1:0]];
  assign mv_count = count;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_btn_move_queue.sv
// Directed bench with a scoreboard: expected move codes are queued when a
// press is issued and a monitor compares them as the bench pops entries.
module tb_btn_move_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn = '0;
  logic       mv_pop = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       mv_valid;
  logic [2:0] mv_code;
  logic [2:0] mv_count;
  logic [4:0] btn_level;
  logic       ovf;

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_q[$];

  btn_move_queue #(.DEBOUNCE_CYCLES(4), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .mv_pop   (mv_pop),
    .ovf_clr  (ovf_clr),
    .mv_valid (mv_valid),
    .mv_code  (mv_code),
    .mv_count (mv_count),
    .btn_level(btn_level),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) begin
      pass_cnt++;
      $display("check %-16s got %0d exp %0d ok", name, act, exp);
    end else begin
      $display("FAIL %s got %0d exp %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && mv_pop && mv_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", int'(mv_code), -1);
      end else begin
        chk("sb_pop_code", int'(mv_code), exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx);
    btn[idx] = 1'b1;
    repeat (10) tick();
    btn[idx] = 1'b0;
    repeat (10) tick();
  endtask

  task automatic pop_one();
    int n;
    n = 0;
    while (!mv_valid && n < 20) begin
      tick();
      n++;
    end
    if (!mv_valid) chk("pop_timeout", 0, 1);
    mv_pop = 1'b1;
    tick();
    mv_pop = 1'b0;
  endtask

  // Count posedges from the current point until mv_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!mv_valid && n < 30);
    if (!mv_valid) n = 99;
  endtask

  task automatic clear_ovf();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // Reset values with every button held.
    btn = 5'b11111;
    repeat (5) tick();
    chk("rst_valid", int'(mv_valid), 0);
    chk("rst_code", int'(mv_code), 0);
    chk("rst_count", int'(mv_count), 0);
    chk("rst_level", int'(btn_level), 0);
    chk("rst_ovf", int'(ovf), 0);

    // Button held across reset release: first posedge after release is E.
    btn = 5'b00001;
    rst_n = 1'b1;
    exp_q.push_back(1);
    wait_valid(lat);
    chk("first_latency", lat, 7);
    chk("first_code", int'(mv_code), 1);
    chk("first_count", int'(mv_count), 1);
    chk("first_level", int'(btn_level), 1);
    btn = '0;
    repeat (10) tick();
    pop_one();
    chk("first_empty", int'(mv_valid), 0);

    // Glitch of 3 cycles rejected, 10-cycle hold accepted.
    btn[2] = 1'b1;
    repeat (3) tick();
    btn[2] = 1'b0;
    repeat (10) tick();
    chk("glitch_level", int'(btn_level), 0);
    chk("glitch_valid", int'(mv_valid), 0);
    exp_q.push_back(3);
    press(2);
    chk("hold_count", int'(mv_count), 1);
    chk("hold_code", int'(mv_code), 3);
    pop_one();

    // Simultaneous down + right: down wins, right dropped.
    exp_q.push_back(2);
    btn = 5'b01010;
    repeat (10) tick();
    chk("simul_level", int'(btn_level), 5'b01010);
    btn = '0;
    repeat (10) tick();
    chk("simul_count", int'(mv_count), 1);
    chk("simul_ovf", int'(ovf), 1);
    clear_ovf();
    chk("simul_ovf_clr", int'(ovf), 0);
    pop_one();

    // Overflow: five presses into a depth-4 queue.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(i + 1);
      press(i);
    end
    chk("ovf_count4", int'(mv_count), 4);
    chk("ovf_before", int'(ovf), 0);
    press(4);
    chk("ovf_count_after", int'(mv_count), 4);
    chk("ovf_after", int'(ovf), 1);
    for (int i = 0; i < 4; i++) pop_one();
    chk("drain_valid", int'(mv_valid), 0);
    chk("drain_code", int'(mv_code), 0);
    clear_ovf();
    chk("drain_ovf_clr", int'(ovf), 0);

    // Full queue, press lands on the same edge as a pop.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(i + 1);
      press(i);
    end
    exp_q.push_back(5);
    btn[4] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    mv_pop = 1'b1;
    tick();
    mv_pop = 1'b0;
    chk("fullpop_count", int'(mv_count), 4);
    chk("fullpop_ovf", int'(ovf), 0);
    chk("fullpop_head", int'(mv_code), 2);
    btn = '0;
    repeat (10) tick();
    for (int i = 0; i < 4; i++) pop_one();

    // Pop while empty.
    mv_pop = 1'b1;
    tick();
    mv_pop = 1'b0;
    chk("empty_pop_count", int'(mv_count), 0);
    chk("empty_pop_valid", int'(mv_valid), 0);

    // Reset mid-operation with entries queued and a debounce running.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(i + 1);
      press(i);
    end
    chk("mid_count", int'(mv_count), 3);
    btn[0] = 1'b1;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", int'(mv_valid), 0);
    chk("async_count", int'(mv_count), 0);
    chk("async_code", int'(mv_code), 0);
    chk("async_level", int'(btn_level), 0);
    chk("async_ovf", int'(ovf), 0);
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    exp_q.push_back(1);
    wait_valid(lat);
    chk("rerelease_lat", lat, 7);
    repeat (20) tick();
    chk("rerelease_count", int'(mv_count), 1);
    btn = '0;
    repeat (10) tick();
    pop_one();
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
